// File: rtl/qam_mapper_param.sv
// Runtime-selectable QPSK/16/64/256-QAM Gray mapper: serial bits in, signed I/Q levels
// out through a small first-word-fall-through queue with valid/ready handshake.
module qam_mapper_param #(
    parameter int unsigned MAX_BITS_PER_AXIS = 4,
    parameter int unsigned AMP_W             = 5,
    parameter int unsigned FIFO_DEPTH        = 4
) (
    input  logic                            data_clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic                            data_in,
    input  logic                            data_valid,
    input  logic                            sym_ready,
    output logic [AMP_W-1:0]                i_data,
    output logic [AMP_W-1:0]                q_data,
    output logic                            sym_valid,
    output logic                            mapping,
    output logic                            fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    input  logic                            overflow_clr
);
    localparam int unsigned MAXB  = MAX_BITS_PER_AXIS;
    localparam int unsigned SR_W  = 2 * MAXB;
    localparam int unsigned CNT_W = $clog2(SR_W + 1);
    localparam int unsigned BPA_W = $clog2(MAXB + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Bits per axis for a mode, capped at the synthesised maximum.
    function automatic logic [BPA_W-1:0] axis_bits(input logic [1:0] md);
        int unsigned n;
        n = 32'(md) + 32'd1;
        if (n > MAXB) n = MAXB;
        return BPA_W'(n);
    endfunction

    function automatic logic [MAXB-1:0] gray2bin(input logic [MAXB-1:0] g);
        logic [MAXB-1:0] b;
        b[MAXB-1] = g[MAXB-1];
        for (int i = int'(MAXB) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Level = 2b - (2^m - 1); modular arithmetic in AMP_W gives the signed result.
    function automatic logic [AMP_W-1:0] to_level(input logic [MAXB-1:0] g,
                                                  input logic [BPA_W-1:0] m);
        logic [AMP_W-1:0] peak;
        peak = (AMP_W'(1) << m) - AMP_W'(1);
        return (AMP_W'(gray2bin(g)) << 1) - peak;
    endfunction

    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, k_eff;
    logic [1:0]       mode_q, mode_n;
    logic [SR_W-1:0]  sr, sr_n, mask;
    logic [BPA_W-1:0] m_eff;
    logic [MAXB-1:0]  i_gray, q_gray;
    logic [AMP_W-1:0] new_i, new_q, head_i, head_q;
    logic [AMP_W-1:0] mem_i [FIFO_DEPTH];
    logic [AMP_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_n, rd_n;
    logic [LVL_W-1:0] level_n;
    logic             accept, complete, pop, push, drop, ovf_n;

    // Next-state: bit assembly, demap, queue bookkeeping.
    always_comb begin
        accept  = enable && data_valid;
        m_eff   = (cnt == '0) ? axis_bits(mode) : axis_bits(mode_q);
        k_eff   = CNT_W'({m_eff, 1'b0});
        sr_n    = accept ? {sr[SR_W-2:0], data_in} : sr;
        cnt_inc = cnt + CNT_W'(1);
        complete = accept && (cnt_inc == k_eff);
        cnt_n   = cnt;
        if (!enable)     cnt_n = '0;
        else if (accept) cnt_n = complete ? '0 : cnt_inc;
        mode_n  = (accept && cnt == '0) ? mode : mode_q;

        mask   = (SR_W'(1) << m_eff) - SR_W'(1);
        i_gray = MAXB'((sr_n >> m_eff) & mask);
        q_gray = MAXB'(sr_n & mask);
        new_i  = to_level(i_gray, m_eff);
        new_q  = to_level(q_gray, m_eff);

        pop     = sym_valid && sym_ready;
        drop    = complete && fifo_full && !pop;
        push    = complete && !drop;
        wr_n    = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_n    = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        level_n = fifo_level + LVL_W'(push) - LVL_W'(pop);

        // A write landing on the new head slot is forwarded directly.
        head_i = i_data;
        head_q = q_data;
        if (level_n != '0) begin
            if (push && rd_n == wr_ptr) begin
                head_i = new_i;
                head_q = new_q;
            end else begin
                head_i = mem_i[rd_n];
                head_q = mem_q[rd_n];
            end
        end

        ovf_n = overflow;
        if (drop)              ovf_n = 1'b1;
        else if (overflow_clr) ovf_n = 1'b0;
    end

    always_ff @(posedge data_clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            mode_q     <= '0;
            sr         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            i_data     <= '0;
            q_data     <= '0;
            sym_valid  <= 1'b0;
            fifo_full  <= 1'b0;
            mapping    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            mode_q     <= mode_n;
            sr         <= sr_n;
            wr_ptr     <= wr_n;
            rd_ptr     <= rd_n;
            fifo_level <= level_n;
            i_data     <= head_i;
            q_data     <= head_q;
            sym_valid  <= (level_n != '0);
            fifo_full  <= (level_n == LVL_W'(FIFO_DEPTH));
            mapping    <= (cnt_n != '0);
            overflow   <= ovf_n;
        end
    end

    // Queue storage needs no reset; occupancy gates every read.
    always_ff @(posedge data_clk) begin
        if (push) begin
            mem_i[wr_ptr] <= new_i;
            mem_q[wr_ptr] <= new_q;
        end
    end
endmodule

// File: tb/tb_qam_mapper_param.sv
// Bench for qam_mapper_param: cycle model with an expected-symbol queue checked every cycle.
module tb_qam_mapper_param;
    localparam int MAXB  = 4;
    localparam int AMP_W = 5;
    localparam int DEPTH = 4;

    logic                       data_clk = 1'b0;
    logic                       rst_n, enable, data_in, data_valid, sym_ready, overflow_clr;
    logic [1:0]                 mode;
    logic [AMP_W-1:0]           i_data, q_data;
    logic                       sym_valid, mapping, fifo_full, overflow;
    logic [$clog2(DEPTH):0]     fifo_level;

    qam_mapper_param #(.MAX_BITS_PER_AXIS(MAXB), .AMP_W(AMP_W), .FIFO_DEPTH(DEPTH)) dut (
        .data_clk(data_clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .data_in(data_in), .data_valid(data_valid), .sym_ready(sym_ready),
        .i_data(i_data), .q_data(q_data), .sym_valid(sym_valid), .mapping(mapping),
        .fifo_full(fifo_full), .fifo_level(fifo_level), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 data_clk = ~data_clk;

    int checks = 0;
    int failures = 0;

    // Expected-symbol scoreboard and model state.
    int sb_i[$];
    int sb_q[$];
    int hold_i, hold_q, m_cnt, m_bits, m_sr;
    bit m_ovf;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_level(input int g, input int m);
        int b;
        b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
        return 2 * b - ((1 << m) - 1);
    endfunction

    // One clock: check registered outputs, advance the model with current inputs, cross the edge.
    task automatic step(input logic dv, input logic din);
        bit pop, full_b, complete;
        int ei, eq, msk;
        data_valid = dv;
        data_in    = din;
        check("sym_valid",  int'(sym_valid),  int'(sb_i.size() != 0));
        check("fifo_level", int'(fifo_level), sb_i.size());
        check("fifo_full",  int'(fifo_full),  int'(sb_i.size() == DEPTH));
        check("mapping",    int'(mapping),    int'(m_cnt != 0));
        check("overflow",   int'(overflow),   int'(m_ovf));
        check("i_data",     int'($signed(i_data)), hold_i);
        check("q_data",     int'($signed(q_data)), hold_q);
        if (!rst_n) begin
            sb_i.delete(); sb_q.delete();
            hold_i = 0; hold_q = 0; m_cnt = 0; m_sr = 0; m_ovf = 0;
        end else begin
            complete = 0; ei = 0; eq = 0;
            if (!enable) begin
                m_cnt = 0; m_sr = 0;
            end else if (dv) begin
                if (m_cnt == 0) m_bits = (int'(mode) + 1 > MAXB) ? MAXB : int'(mode) + 1;
                m_sr = (m_sr << 1) | int'(din);
                m_cnt++;
                if (m_cnt == 2 * m_bits) begin
                    msk = (1 << m_bits) - 1;
                    ei = exp_level((m_sr >> m_bits) & msk, m_bits);
                    eq = exp_level(m_sr & msk, m_bits);
                    complete = 1; m_cnt = 0; m_sr = 0;
                end
            end
            full_b = (sb_i.size() == DEPTH);
            pop    = (sb_i.size() != 0) && sym_ready;
            if (pop) begin
                void'(sb_i.pop_front()); void'(sb_q.pop_front());
            end
            if (complete && full_b && !pop) m_ovf = 1;
            else begin
                if (complete) begin sb_i.push_back(ei); sb_q.push_back(eq); end
                if (overflow_clr) m_ovf = 0;
            end
            if (sb_i.size() != 0) begin hold_i = sb_i[0]; hold_q = sb_q[0]; end
        end
        @(negedge data_clk); #1;
    endtask

    task automatic send(input int val, input int n);
        for (int j = n - 1; j >= 0; j--) step(1'b1, 1'(val >> j));
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 0; enable = 1; mode = 2'd1; data_in = 0; data_valid = 0;
        sym_ready = 1; overflow_clr = 0;
        hold_i = 0; hold_q = 0; m_cnt = 0; m_bits = 1; m_sr = 0; m_ovf = 0;
        repeat (2) @(posedge data_clk);
        @(negedge data_clk); #1;
        rst_n = 1;

        // 16-QAM 1011 -> +3/+1 one cycle after the last bit
        mode = 2'd1;
        step(1'b1, 1'b1);
        check("t1_map_b2", int'(mapping), 1);
        send(3'b011, 3);
        check("t1_valid", int'(sym_valid), 1);
        check("t1_i", int'($signed(i_data)), 3);
        check("t1_q", int'($signed(q_data)), 1);
        check("t1_map_after", int'(mapping), 0);
        idle(1);

        mode = 2'd0; send(2'b01, 2);
        check("qpsk_i", int'($signed(i_data)), -1);
        check("qpsk_q", int'($signed(q_data)), 1);
        mode = 2'd2; send(6'b000000, 6);
        check("q64_i", int'($signed(i_data)), -7);
        check("q64_q", int'($signed(q_data)), -7);
        mode = 2'd3; send(8'b10000000, 8);
        check("q256_i", int'($signed(i_data)), 15);
        check("q256_q", int'($signed(q_data)), -15);
        idle(2);

        // Mode switch 1->3 after the 2nd bit: still 16-QAM, then an 8-bit symbol
        mode = 2'd1; send(2'b11, 2);
        mode = 2'd3; send(2'b10, 2);
        check("sw_i", int'($signed(i_data)), 1);
        check("sw_q", int'($signed(q_data)), 3);
        send(8'b01100101, 8);
        idle(2);

        // Overflow: five QPSK symbols into a stalled 4-entry queue
        mode = 2'd0; sym_ready = 0;
        for (int s = 0; s < 5; s++) send(s & 3, 2);
        check("ovf_level", int'(fifo_level), 4);
        check("ovf_full", int'(fifo_full), 1);
        check("ovf_set", int'(overflow), 1);
        sym_ready = 1; idle(4);
        check("drain_level", int'(fifo_level), 0);
        check("ovf_sticky", int'(overflow), 1);
        overflow_clr = 1; idle(1); overflow_clr = 0;
        check("ovf_clr", int'(overflow), 0);

        // Full queue with a pop coinciding with the completing bit
        sym_ready = 0;
        for (int s = 0; s < 4; s++) send(s, 2);
        step(1'b1, 1'b1);
        sym_ready = 1; step(1'b1, 1'b0);
        check("pp_level", int'(fifo_level), 4);
        check("pp_ovf", int'(overflow), 0);
        idle(5);

        // Enable dropped mid 64-QAM symbol, then a fresh symbol
        mode = 2'd2; send(3'b111, 3);
        enable = 0; step(1'b1, 1'b1); enable = 1;
        check("en_map", int'(mapping), 0);
        send(6'b101001, 6);
        idle(2);

        // Reset mid-symbol with two queued entries
        mode = 2'd0; sym_ready = 0;
        send(2'b10, 2); send(2'b01, 2); step(1'b1, 1'b1);
        rst_n = 0; step(1'b1, 1'b0); rst_n = 1;
        check("rst_valid", int'(sym_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_map", int'(mapping), 0);
        sym_ready = 1;

        // Random symbols, modes and backpressure
        for (int s = 0; s < 40; s++) begin
            mode = 2'($urandom_range(0, 3));
            for (int b = 0; b < 2 * (int'(mode) + 1); b++) begin
                sym_ready = 1'($urandom_range(0, 1));
                overflow_clr = ($urandom_range(0, 7) == 0);
                step(1'($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
            end
        end
        overflow_clr = 0; sym_ready = 1;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
